// File: rtl/id_ex_pkg.sv
// id_ex_pkg: shared definitions for the ID/EX pipeline register.
//   - CTRL bit positions inside the 8-bit decoded control bundle
//     {ALU_OP[1:0],BRANCH,MEM_TO_REG,ALU_SRC,MEM_WRITE,MEM_READ,REG_WRITE}
//   - ctrl_t packed view of the same bundle
//   - XZR_IDX: architectural zero register index
package id_ex_pkg;

  localparam int CTRL_W       = 8;
  localparam int REG_WRITE_B  = 0;
  localparam int MEM_READ_B   = 1;
  localparam int MEM_WRITE_B  = 2;
  localparam int ALU_SRC_B    = 3;
  localparam int MEM_TO_REG_B = 4;
  localparam int BRANCH_B     = 5;
  localparam int ALU_OP_LSB   = 6;
  localparam int XZR_IDX      = 31;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       branch;
    logic       mem_to_reg;
    logic       alu_src;
    logic       mem_write;
    logic       mem_read;
    logic       reg_write;
  } ctrl_t;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// load_use_detect: combinational load-use hazard detector.
// Ports:
//   id_valid, id_rn, id_rm   - instruction currently in ID and its sources
//   ex_valid, ex_mem_read,
//   ex_rd                    - load candidate currently held in EX
//   flush, rst               - suppress the stall (squash wins, reset drops it)
//   stall                    - freeze PC and IF/ID, insert a bubble into EX
module load_use_detect
  import id_ex_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rn,
  input  logic [REG_AW-1:0] id_rm,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              flush,
  input  logic              rst,
  output logic              stall
);

  logic ex_rd_real;
  logic src_match;

  // A load targeting XZR writes nothing, so nothing can depend on it.
  assign ex_rd_real = (ex_rd != REG_AW'(XZR_IDX));
  assign src_match  = (ex_rd == id_rn) || (ex_rd == id_rm);

  assign stall = id_valid && ex_valid && ex_mem_read && ex_rd_real &&
                 src_match && !flush && !rst;

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register directly behind the register file.
// Captures bypassed register operands, immediate, PC, indices and control for
// EX; detects load-use hazards and stalls the front end for one cycle.
// Ports:
//   CLK, RESET (sync, active-high)
//   ID_*  : instruction in ID plus register-file read data
//   WB_*  : write-back port (same-cycle write is forwarded into capture)
//   FLUSH : taken branch, squash ID instruction
//   STALL : combinational hold request for PC and IF/ID
//   EX_*  : registered outputs for the EX stage
// Optional build macro ID_EX_STALL_CNT_EN adds STALL_COUNT[31:0], a saturating
// count of stalled cycles cleared by RESET.
module id_ex_stage #(
  parameter int DATA_W = 64,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ID_VALID,
  input  logic [DATA_W-1:0] ID_PC,
  input  logic [REG_AW-1:0] ID_RN,
  input  logic [REG_AW-1:0] ID_RM,
  input  logic [REG_AW-1:0] ID_RD,
  input  logic [DATA_W-1:0] ID_DATA_A,
  input  logic [DATA_W-1:0] ID_DATA_B,
  input  logic [DATA_W-1:0] ID_IMM,
  input  logic [CTRL_W-1:0] ID_CTRL,
  input  logic              WB_REG_WRITE,
  input  logic [REG_AW-1:0] WB_RD,
  input  logic [DATA_W-1:0] WB_DATA,
  input  logic              FLUSH,
  output logic              STALL,
  output logic              EX_VALID,
  output logic [DATA_W-1:0] EX_PC,
  output logic [DATA_W-1:0] EX_DATA_A,
  output logic [DATA_W-1:0] EX_DATA_B,
  output logic [DATA_W-1:0] EX_IMM,
  output logic [REG_AW-1:0] EX_RN,
  output logic [REG_AW-1:0] EX_RM,
  output logic [REG_AW-1:0] EX_RD,
`ifdef ID_EX_STALL_CNT_EN
  output logic [31:0]       STALL_COUNT,
`endif
  output logic [CTRL_W-1:0] EX_CTRL
);

  import id_ex_pkg::*;

  logic [DATA_W-1:0] a_sel_p0;
  logic [DATA_W-1:0] b_sel_p0;
  logic              stall_p0;

  logic              vld_p1;
  logic [DATA_W-1:0] pc_p1;
  logic [DATA_W-1:0] data_a_p1;
  logic [DATA_W-1:0] data_b_p1;
  logic [DATA_W-1:0] imm_p1;
  logic [REG_AW-1:0] rn_p1;
  logic [REG_AW-1:0] rm_p1;
  logic [REG_AW-1:0] rd_p1;
  logic [CTRL_W-1:0] ctrl_p1;

  // ---- ID (p0): write-back bypass and hazard detection ----
  // The register file writes on the edge but reads asynchronously, so a write
  // landing this cycle must be forwarded here. XZR is never forwarded.
  assign a_sel_p0 = (WB_REG_WRITE && (WB_RD == ID_RN) && (ID_RN != REG_AW'(XZR_IDX)))
                    ? WB_DATA : ID_DATA_A;
  assign b_sel_p0 = (WB_REG_WRITE && (WB_RD == ID_RM) && (ID_RM != REG_AW'(XZR_IDX)))
                    ? WB_DATA : ID_DATA_B;

  load_use_detect #(.REG_AW(REG_AW)) u_load_use_detect (
    .id_valid    (ID_VALID),
    .id_rn       (ID_RN),
    .id_rm       (ID_RM),
    .ex_valid    (vld_p1),
    .ex_mem_read (ctrl_p1[MEM_READ_B]),
    .ex_rd       (rd_p1),
    .flush       (FLUSH),
    .rst         (RESET),
    .stall       (stall_p0)
  );

  assign STALL = stall_p0;

  // ---- ID -> EX (p1) register ----
  // A bubble clears valid and control only; operand fields are held, which
  // also means the bubble clears MEM_READ and limits a stall to one cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      vld_p1    <= 1'b0;
      ctrl_p1   <= '0;
      pc_p1     <= '0;
      data_a_p1 <= '0;
      data_b_p1 <= '0;
      imm_p1    <= '0;
      rn_p1     <= '0;
      rm_p1     <= '0;
      rd_p1     <= '0;
    end else if (FLUSH || stall_p0) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= '0;
    end else begin
      vld_p1    <= ID_VALID;
      ctrl_p1   <= ID_VALID ? ID_CTRL : '0;
      pc_p1     <= ID_PC;
      data_a_p1 <= a_sel_p0;
      data_b_p1 <= b_sel_p0;
      imm_p1    <= ID_IMM;
      rn_p1     <= ID_RN;
      rm_p1     <= ID_RM;
      rd_p1     <= ID_RD;
    end
  end

  assign EX_VALID  = vld_p1;
  assign EX_CTRL   = ctrl_p1;
  assign EX_PC     = pc_p1;
  assign EX_DATA_A = data_a_p1;
  assign EX_DATA_B = data_b_p1;
  assign EX_IMM    = imm_p1;
  assign EX_RN     = rn_p1;
  assign EX_RM     = rm_p1;
  assign EX_RD     = rd_p1;

`ifdef ID_EX_STALL_CNT_EN
  logic [31:0] stall_cnt_p1;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // ---- stall counter (p1) ----
  always_ff @(posedge CLK) begin
    if (RESET) begin
      stall_cnt_p1 <= '0;
    end else if (stall_p0) begin
      stall_cnt_p1 <= sat_inc32(stall_cnt_p1);
    end
  end

  assign STALL_COUNT = stall_cnt_p1;
`endif

endmodule
